// File: rtl/axi_stream_split_channel_if.sv
// AXI-Stream channel bundle shared by the origin, head and tail ports of the splitter.
// master drives the payload and tvalid, slave drives tready.
interface axi_stream_split_channel_if #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned USIZE = 1,
  parameter int unsigned KSIZE = (DSIZE / 8 < 1) ? 1 : DSIZE / 8
);
  logic             tvalid;
  logic             tready;
  logic [DSIZE-1:0] tdata;
  logic [KSIZE-1:0] tkeep;
  logic [USIZE-1:0] tuser;
  logic             tlast;

  modport master (output tvalid, tdata, tkeep, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tuser, tlast, output tready);
endinterface

// File: rtl/axi_stream_split_channel.sv
// Splits each AXI-Stream packet: the first split_len beats go to first_ch, the rest to end_ch.
// Each output has a one-entry register; origin is backpressured only by the selected output.
module axi_stream_split_channel #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned USIZE = 1,
  parameter int unsigned KSIZE = (DSIZE / 8 < 1) ? 1 : DSIZE / 8
) (
  input  logic                              clock,
  input  logic                              rst_n,
  input  logic [15:0]                       split_len,
  axi_stream_split_channel_if.slave         origin_ch,
  axi_stream_split_channel_if.master        first_ch,
  axi_stream_split_channel_if.master        end_ch
);

  logic [15:0]      cnt_q;
  logic [15:0]      len_q;
  logic [15:0]      eff_len;
  logic             to_first;
  logic             hit_len;
  logic             first_load;
  logic             end_load;
  logic             accept;

  logic             first_valid_q;
  logic [DSIZE-1:0] first_data_q;
  logic [KSIZE-1:0] first_keep_q;
  logic [USIZE-1:0] first_user_q;
  logic             first_last_q;

  logic             end_valid_q;
  logic [DSIZE-1:0] end_data_q;
  logic [KSIZE-1:0] end_keep_q;
  logic [USIZE-1:0] end_user_q;
  logic             end_last_q;

  // cnt_q holds the number of beats already accepted, so the current beat index is cnt_q + 1.
  assign eff_len    = (cnt_q == 16'd0) ? split_len : len_q;
  assign to_first   = cnt_q < eff_len;
  assign hit_len    = ({1'b0, cnt_q} + 17'd1) == {1'b0, eff_len};
  assign first_load = !first_valid_q || first_ch.tready;
  assign end_load   = !end_valid_q || end_ch.tready;

  assign origin_ch.tready = rst_n && (to_first ? first_load : end_load);
  assign accept           = origin_ch.tvalid && origin_ch.tready;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      cnt_q         <= 16'd0;
      len_q         <= 16'd0;
      first_valid_q <= 1'b0;
      end_valid_q   <= 1'b0;
    end else begin
      if (accept) begin
        if (cnt_q == 16'd0) len_q <= split_len;
        if (origin_ch.tlast) begin
          cnt_q <= 16'd0;
        end else if (cnt_q != 16'hffff) begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
      if (first_load) first_valid_q <= accept && to_first;
      if (end_load)   end_valid_q   <= accept && !to_first;
    end
  end

  // Payload registers need no reset; they are only observed while the matching valid is set.
  always_ff @(posedge clock) begin
    if (accept && to_first) begin
      first_data_q <= origin_ch.tdata;
      first_keep_q <= origin_ch.tkeep;
      first_user_q <= origin_ch.tuser;
      first_last_q <= origin_ch.tlast || hit_len;
    end
    if (accept && !to_first) begin
      end_data_q <= origin_ch.tdata;
      end_keep_q <= origin_ch.tkeep;
      end_user_q <= origin_ch.tuser;
      end_last_q <= origin_ch.tlast;
    end
  end

  assign first_ch.tvalid = first_valid_q;
  assign first_ch.tdata  = first_data_q;
  assign first_ch.tkeep  = first_keep_q;
  assign first_ch.tuser  = first_user_q;
  assign first_ch.tlast  = first_last_q;

  assign end_ch.tvalid = end_valid_q;
  assign end_ch.tdata  = end_data_q;
  assign end_ch.tkeep  = end_keep_q;
  assign end_ch.tuser  = end_user_q;
  assign end_ch.tlast  = end_last_q;

endmodule

// File: tb/tb_axi_stream_split_channel.sv
// Bench for axi_stream_split_channel: directed vector table, randomized packet loops against a
// packet-level reference model, and a mid-packet reset sequence.
module tb_axi_stream_split_channel;
  localparam int BW = 11;  // tdata(8) + tkeep(1) + tuser(1) + tlast(1)

  typedef struct {
    int split;
    int len;
    int split2;
    int exp_nf;
    int exp_ne;
  } vec_t;

  logic        clock;
  logic        rst_n;
  logic [15:0] split_len;
  int          pf;
  int          pe;
  int          n_chk;
  int          n_fail;
  int          f_beats, e_beats, f_lasts, e_lasts;
  logic [BW-1:0] exp_f[$];
  logic [BW-1:0] exp_e[$];
  logic [BW-1:0] got_f, got_e, held_f, held_e, cur_f, cur_e;
  logic          hold_f, hold_e;

  axi_stream_split_channel_if origin_ch ();
  axi_stream_split_channel_if first_ch ();
  axi_stream_split_channel_if end_ch ();

  axi_stream_split_channel dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .split_len (split_len),
    .origin_ch (origin_ch),
    .first_ch  (first_ch),
    .end_ch    (end_ch)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output readiness is regenerated every cycle from the current percentages.
  initial begin
    first_ch.tready = 1'b0;
    end_ch.tready   = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      first_ch.tready = ($urandom_range(0, 99) < pf);
      end_ch.tready   = ($urandom_range(0, 99) < pe);
    end
  end

  // Monitor: a handshake seen on the falling edge completes on the next rising edge.
  always @(negedge clock) begin
    cur_f = {first_ch.tdata, first_ch.tkeep, first_ch.tuser, first_ch.tlast};
    cur_e = {end_ch.tdata, end_ch.tkeep, end_ch.tuser, end_ch.tlast};
    if (rst_n && hold_f) check("first_stable", {first_ch.tvalid, cur_f}, {1'b1, held_f});
    if (rst_n && hold_e) check("end_stable", {end_ch.tvalid, cur_e}, {1'b1, held_e});
    hold_f = rst_n && first_ch.tvalid && !first_ch.tready;
    hold_e = rst_n && end_ch.tvalid && !end_ch.tready;
    held_f = cur_f;
    held_e = cur_e;
    if (rst_n && first_ch.tvalid && first_ch.tready) begin
      f_beats++;
      if (first_ch.tlast) f_lasts++;
      if (exp_f.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL first_unexpected_beat: got %0h, expected no beat", cur_f);
      end else begin
        got_f = exp_f.pop_front();
        check("first_beat", cur_f, got_f);
      end
    end
    if (rst_n && end_ch.tvalid && end_ch.tready) begin
      e_beats++;
      if (end_ch.tlast) e_lasts++;
      if (exp_e.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL end_unexpected_beat: got %0h, expected no beat", cur_e);
      end else begin
        got_e = exp_e.pop_front();
        check("end_beat", cur_e, got_e);
      end
    end
  end

  // Drives one packet and records its expected head/tail beats; split is latched at beat 1 (s1).
  task automatic send_packet(input int len, input int s1, input int s2, input int gap,
                             output int stalls);
    logic [BW-1:0] b;
    int nf;
    bit acc;
    stalls = 0;
    nf = (len < s1) ? len : s1;
    for (int i = 1; i <= len; i++) begin
      b = {8'($urandom), 1'($urandom), 1'($urandom), 1'(i == len)};
      if (i <= nf) exp_f.push_back({b[BW-1:1], 1'(i == nf)});
      else exp_e.push_back(b);
      while (gap > 0 && $urandom_range(0, 99) < gap) begin
        origin_ch.tvalid = 1'b0;
        @(posedge clock);
        #1;
      end
      origin_ch.tvalid = 1'b1;
      {origin_ch.tdata, origin_ch.tkeep, origin_ch.tuser, origin_ch.tlast} = b;
      split_len = (i == 1) ? 16'(s1) : 16'(s2);
      acc = 1'b0;
      for (int t = 0; t < 2000 && !acc; t++) begin
        @(negedge clock);
        acc = origin_ch.tready;
        if (!acc) stalls++;
        @(posedge clock);
        #1;
      end
      if (!acc) begin
        check("origin_accept_timeout", 0, 1);
        origin_ch.tvalid = 1'b0;
        return;
      end
    end
    origin_ch.tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 3000 && (exp_f.size() != 0 || exp_e.size() != 0); t++) @(posedge clock);
    repeat (4) @(posedge clock);
    #1;
    check("first_queue_drained", exp_f.size(), 0);
    check("end_queue_drained", exp_e.size(), 0);
  endtask

  vec_t vecs[5];
  int   rlen[8];
  int   rsplit[8];
  int   ppf[3];
  int   ppe[3];
  int   stalls, fb0, eb0, fl0, el0;

  initial begin
    vecs[0] = '{split: 3, len: 5, split2: 3, exp_nf: 3, exp_ne: 2};
    vecs[1] = '{split: 0, len: 4, split2: 0, exp_nf: 0, exp_ne: 4};
    vecs[2] = '{split: 8, len: 5, split2: 8, exp_nf: 5, exp_ne: 0};
    vecs[3] = '{split: 4, len: 4, split2: 4, exp_nf: 4, exp_ne: 0};
    vecs[4] = '{split: 2, len: 5, split2: 6, exp_nf: 2, exp_ne: 3};
    rlen    = '{1, 40, 17, 63, 5, 30, 52, 38};
    rsplit  = '{0, 10, 17, 70, 2, 0, 1, 38};
    ppf     = '{50, 100, 30};
    ppe     = '{100, 50, 100};

    n_chk = 0; n_fail = 0;
    f_beats = 0; e_beats = 0; f_lasts = 0; e_lasts = 0;
    hold_f = 1'b0; hold_e = 1'b0;
    pf = 100; pe = 100;
    rst_n = 1'b0;
    split_len = 16'd0;
    origin_ch.tvalid = 1'b0;
    origin_ch.tdata = '0; origin_ch.tkeep = '0; origin_ch.tuser = '0; origin_ch.tlast = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_first_tvalid", first_ch.tvalid, 0);
    check("reset_end_tvalid", end_ch.tvalid, 0);
    check("reset_origin_tready", origin_ch.tready, 0);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    @(negedge clock);
    check("post_reset_origin_tready", origin_ch.tready, 1);
    @(posedge clock);
    #1;

    // Directed vectors with both outputs always ready: no origin stall is allowed.
    for (int v = 0; v < 5; v++) begin
      fb0 = f_beats; eb0 = e_beats; fl0 = f_lasts; el0 = e_lasts;
      send_packet(vecs[v].len, vecs[v].split, vecs[v].split2, 0, stalls);
      drain();
      check($sformatf("vec%0d_first_beats", v), f_beats - fb0, vecs[v].exp_nf);
      check($sformatf("vec%0d_end_beats", v), e_beats - eb0, vecs[v].exp_ne);
      check($sformatf("vec%0d_first_lasts", v), f_lasts - fl0, (vecs[v].exp_nf > 0) ? 1 : 0);
      check($sformatf("vec%0d_end_lasts", v), e_lasts - el0, (vecs[v].exp_ne > 0) ? 1 : 0);
      check($sformatf("vec%0d_origin_stalls", v), stalls, 0);
    end

    // Eight looped packets (246 beats) under three backpressure profiles.
    for (int ph = 0; ph < 3; ph++) begin
      pf = ppf[ph]; pe = ppe[ph];
      fb0 = f_beats; eb0 = e_beats; fl0 = f_lasts; el0 = e_lasts;
      for (int p = 0; p < 8; p++)
        send_packet(rlen[p], rsplit[p], $urandom_range(0, 80), 20, stalls);
      drain();
      check($sformatf("loop%0d_first_beats", ph), f_beats - fb0, 131);
      check($sformatf("loop%0d_end_beats", ph), e_beats - eb0, 115);
      check($sformatf("loop%0d_first_lasts", ph), f_lasts - fl0, 6);
      check($sformatf("loop%0d_end_lasts", ph), e_lasts - el0, 5);
    end

    // Mid-packet reset with a head beat stuck in the first register.
    pf = 0; pe = 100;
    repeat (3) @(posedge clock);
    #1;
    origin_ch.tvalid = 1'b1;
    {origin_ch.tdata, origin_ch.tkeep, origin_ch.tuser, origin_ch.tlast} = 11'h5a4;
    split_len = 16'd4;
    @(negedge clock);
    check("rst_seq_beat1_ready", origin_ch.tready, 1);
    @(posedge clock);
    #1;
    {origin_ch.tdata, origin_ch.tkeep, origin_ch.tuser, origin_ch.tlast} = 11'h3c2;
    @(negedge clock);
    check("rst_seq_beat2_blocked", origin_ch.tready, 0);
    check("rst_seq_first_pending", first_ch.tvalid, 1);
    @(posedge clock);
    #1;
    rst_n = 1'b0;
    origin_ch.tvalid = 1'b0;
    @(negedge clock);
    check("rst_seq_tready_low", origin_ch.tready, 0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("rst_seq_first_tvalid", first_ch.tvalid, 0);
    check("rst_seq_end_tvalid", end_ch.tvalid, 0);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    pf = 100;
    exp_f.delete();
    exp_e.delete();
    @(negedge clock);
    check("rst_seq_ready_after_release", origin_ch.tready, 1);
    @(posedge clock);
    #1;
    fb0 = f_beats; eb0 = e_beats; fl0 = f_lasts; el0 = e_lasts;
    send_packet(3, 2, 2, 0, stalls);
    drain();
    check("rst_seq_first_beats", f_beats - fb0, 2);
    check("rst_seq_end_beats", e_beats - eb0, 1);
    check("rst_seq_first_lasts", f_lasts - fl0, 1);
    check("rst_seq_end_lasts", e_lasts - el0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
